ex1_sweep_ctrl: RTL and testbench

- Self-checking sweep sequencer for the 4-input combinational function block (inputs a, b, c, d; output y).
- On a start pulse it drives all 16 input combinations in order {a,b,c,d} = 0000 to 1111 and waits a settle time per vector.
- It samples y, assembles the captured 16-bit truth table and compares each bit against an expected table.
- It sits between a top-level test/control FSM and the function block, and replaces the hand-written sweep with hardware.

---
 rtl/ex1_sweep_ctrl_if.sv | 22 ++
 rtl/ex1_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_ex1_sweep_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ex1_sweep_ctrl_if.sv
// ex1_sweep_ctrl_if: control/status and function-block signals of the sweep sequencer.
interface ex1_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        y_in;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_err_idx;
  logic        err_seen;
  modport master (
    output start, abort, y_in,
    input  a, b, c, d, busy, done, pass, tt, mismatch_cnt, first_err_idx, err_seen
  );
  modport slave (
    input  start, abort, y_in,
    output a, b, c, d, busy, done, pass, tt, mismatch_cnt, first_err_idx, err_seen
  );
endinterface

// File: rtl/ex1_sweep_ctrl.sv
// ex1_sweep_ctrl: sweeps 16 input vectors, captures y and compares against EXPECTED.
// Define SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module ex1_sweep_ctrl #(
  parameter int          SETTLE_CYC = 2,
  parameter logic [15:0] EXPECTED   = 16'h0000
) (
  input logic             clk,
  input logic             rst_n,
  ex1_sweep_ctrl_if.slave ctrl
);
  localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CW = (SC < 2) ? 1 : $clog2(SC);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt, first, first_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0] tt, tt_nxt;
  logic [4:0]  mis, mis_nxt;
  logic        err, err_nxt, pass, pass_nxt, miss, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      tt    <= '0;
      mis   <= '0;
      first <= '0;
      err   <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      tt    <= tt_nxt;
      mis   <= mis_nxt;
      first <= first_nxt;
      err   <= err_nxt;
      pass  <= pass_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    tt_nxt    = tt;
    mis_nxt   = mis;
    first_nxt = first;
    err_nxt   = err;
    pass_nxt  = pass;
    miss      = ctrl.y_in != EXPECTED[idx];
`ifdef SWEEP_STOP_ON_ERR_EN
    last      = (idx == 4'd15) || miss;
`else
    last      = idx == 4'd15;
`endif
    case (state)
      IDLE: if (ctrl.start) begin
        state_nxt = SETTLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        tt_nxt    = '0;
        mis_nxt   = '0;
        first_nxt = '0;
        err_nxt   = 1'b0;
        pass_nxt  = 1'b0;
      end
      SETTLE: if (ctrl.abort) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        pass_nxt  = 1'b0;
      end else if (cnt == CW'(SC - 1)) begin
        state_nxt = SAMPLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      SAMPLE: if (ctrl.abort) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        pass_nxt  = 1'b0;
      end else begin
        tt_nxt[idx] = ctrl.y_in;
        if (miss) begin
          mis_nxt = (mis == 5'd16) ? mis : mis + 5'd1;
          if (!err) begin
            first_nxt = idx;
            err_nxt   = 1'b1;
          end
        end
        // pass is settled on entry to DONE so it is valid alongside the done pulse
        if (last) begin
          state_nxt = DONE;
          pass_nxt  = mis_nxt == 5'd0;
        end else begin
          state_nxt = SETTLE;
          idx_nxt   = idx + 4'd1;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign {ctrl.a, ctrl.b, ctrl.c, ctrl.d} = idx;
  assign ctrl.busy          = state != IDLE;
  assign ctrl.done          = state == DONE;
  assign ctrl.pass          = pass;
  assign ctrl.tt            = tt;
  assign ctrl.mismatch_cnt  = mis;
  assign ctrl.first_err_idx = first;
  assign ctrl.err_seen      = err;
endmodule

// File: tb/tb_ex1_sweep_ctrl.sv
// tb_ex1_sweep_ctrl: scoreboard bench for the sweep sequencer driving a modelled function block.
module tb_ex1_sweep_ctrl;
  localparam int          SETTLE = 2;
  localparam logic [15:0] EXP    = 16'hF444;
  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        err;
    logic        pass;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   stuck = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  ex1_sweep_ctrl_if bus();
  ex1_sweep_ctrl #(.SETTLE_CYC(SETTLE), .EXPECTED(EXP)) dut (.clk(clk), .rst_n(rst_n), .ctrl(bus));
  always #5 clk = ~clk;
  always_comb bus.y_in = stuck ? 1'b0 : ((bus.a & bus.b) | (bus.c & ~bus.d));
  function automatic logic model_y(int i, bit s);
    logic [3:0] v = i[3:0];
    return s ? 1'b0 : ((v[3] & v[2]) | (v[1] & ~v[0]));
  endfunction
  function automatic exp_t predict(bit s);
    exp_t e;
    e.tt = '0; e.cnt = '0; e.first = '0; e.err = 1'b0;
    e.lat = 16 * (SETTLE + 1) + 1;
    for (int i = 0; i < 16; i++) begin
      logic y;
      y = model_y(i, s);
      e.tt[i] = y;
      if (y !== EXP[i]) begin
        e.cnt = e.cnt + 5'd1;
        if (!e.err) begin
          e.first = i[3:0];
          e.err = 1'b1;
        end
`ifdef SWEEP_STOP_ON_ERR_EN
        e.lat = (i + 1) * (SETTLE + 1) + 1;
        break;
`endif
      end
    end
    e.pass = e.cnt == 5'd0;
    return e;
  endfunction
  task automatic pulse_start(input bit with_abort);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = with_abort;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask
  task automatic check_idle_zero(input string tag);
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.err_seen, bus.a, bus.b, bus.c, bus.d} !== 8'h00 ||
        bus.tt !== 16'h0 || bus.mismatch_cnt !== 5'd0 || bus.first_err_idx !== 4'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b pass=%b err=%b abcd=%b%b%b%b tt=%h cnt=%0d first=%0d, need all zero",
               tag, bus.busy, bus.done, bus.pass, bus.err_seen, bus.a, bus.b, bus.c, bus.d,
               bus.tt, bus.mismatch_cnt, bus.first_err_idx);
    end
  endtask
  task automatic watch_no_done(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: done/busy seen after termination, need idle", tag);
    end
  endtask
  task automatic sweep(input string tag, input bit s, input bit restart, input bit with_abort);
    exp_t e;
    int cyc = 0;
    bit got = 1'b0;
    stuck = s;
    sb.push_back(predict(s));
    pulse_start(with_abort);
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (restart && cyc == 10) bus.start = 1'b1;
      if (restart && cyc == 11) bus.start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b need 1", tag, bus.busy);
        end
      end
      if (bus.done === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, cyc);
      return;
    end
    if (cyc != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d need %0d", tag, cyc, e.lat);
    end
    checks++;
    if (bus.tt !== e.tt || bus.mismatch_cnt !== e.cnt || bus.first_err_idx !== e.first ||
        bus.err_seen !== e.err || bus.pass !== e.pass) begin
      errors++;
      $display("FAIL %s results: tt=%h cnt=%0d first=%0d err=%b pass=%b need tt=%h cnt=%0d first=%0d err=%b pass=%b",
               tag, bus.tt, bus.mismatch_cnt, bus.first_err_idx, bus.err_seen, bus.pass,
               e.tt, e.cnt, e.first, e.err, e.pass);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== e.pass) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b pass=%b need 0 0 %b", tag, bus.done, bus.busy, bus.pass, e.pass);
    end
  endtask
  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_release");
  endtask
  task automatic test_good_sweep();
    sweep("good", 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_stuck_sweep();
    sweep("stuck", 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_start_while_busy();
    sweep("restart", 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_abort();
    int n = 0;
    stuck = 1'b0;
    pulse_start(1'b0);
    while (!(bus.busy && {bus.a, bus.b, bus.c, bus.d} == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || {bus.a, bus.b, bus.c, bus.d} !== 4'd0 || bus.pass !== 1'b0 ||
        bus.done !== 1'b0 || bus.tt !== 16'h0004) begin
      errors++;
      $display("FAIL abort: busy=%b abcd=%b%b%b%b pass=%b done=%b tt=%h need 0 0000 0 0 0004",
               bus.busy, bus.a, bus.b, bus.c, bus.d, bus.pass, bus.done, bus.tt);
    end
    watch_no_done("abort_quiet", 60);
    sweep("after_abort", 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_async_reset();
    stuck = 1'b0;
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    watch_no_done("reset_quiet", 60);
  endtask
  task automatic test_back_to_back();
    sweep("b2b_stuck", 1'b1, 1'b0, 1'b0);
    sweep("b2b_start_abort", 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    test_reset();
    test_good_sweep();
    test_stuck_sweep();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
